// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: word-addressed backing store behind a
// req/ack handshake with a fixed access latency and a CPU stall output.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          bad_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];
  logic          accept;
  logic          commit;
  logic          bad_d;

  // Error is decided at acceptance so the commit edge only needs the latched flag
  assign bad_d = (addr_i[1:0] != 2'b00) | (addr_i[31:2] >= DEPTH_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        idx_q   <= addr_i[AW+1:2];
        wdata_q <= wdata_i;
        bad_q   <= bad_d;
      end
      // Store commits leave the read-data register untouched
      if (commit) begin
        err_q <= bad_q;
        if (bad_q) begin
          rdata_q <= '0;
        end else if (!we_q) begin
          rdata_q <= mem_q[idx_q];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit && we_q && !bad_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign ack_o   = (state_q == RESP);
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign stall_o = req_i & ~ack_o;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder. It serves the CPU's load/store requests (addr, write data, read/write) through a req/ack handshake with a configurable access latency.
- It replaces the single-cycle data memory behind the CPU datapath.
- It provides a stall output so the CPU can freeze PC and register-file writes until the access completes.
- Word-addressed backing store, internal to the block.

Parameters:
DEPTH, 128, number of 32-bit words in the backing store (power of two, >=4)
LATENCY, 3, clock edges from request acceptance to ack assertion (>=1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
req_i  input  1  access request; held high with stable we_i/addr_i/wdata_i until ack_o
we_i  input  1  1 = store word, 0 = load word
addr_i  input  32  byte address
wdata_i  input  32  store data
ready_o  output  1  block idle, request will be accepted on next edge
ack_o  output  1  one-cycle completion pulse
rdata_o  output  32  load data, valid while ack_o=1
err_o  output  1  error flag, valid with ack_o
stall_o  output  1  CPU freeze = req_i & ~ack_o (combinational)

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, counter=0, all memory words=0, ready_o=1, ack_o=0, rdata_o=0, err_o=0, latched request cleared.
- Reset mid-access discards the access; an uncommitted store never reaches memory.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - ready_o=1.
  - On an edge with req_i=1: latch we/addr/wdata, load counter=LATENCY-1, go BUSY.
  - Compute error at latch: err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
- BUSY:
  - ready_o=0. Counter decrements each edge.
  - On the edge where counter==0, go RESP and commit the access:
    - if no error and we=1: mem[addr[31:2]] <= wdata.
    - if no error and we=0: rdata_o <= mem[addr[31:2]].
    - if error: no memory change, rdata_o <= 0, err_o <= 1.
    - otherwise err_o <= 0.
- RESP:
  - ack_o=1, ready_o=0 for exactly one cycle, then go IDLE unconditionally.
  - req_i is not sampled in RESP, so back-to-back requests see one IDLE cycle.
- Latency: request sampled at edge T; ack_o registered at edge T+LATENCY, high for the cycle after it. Next request can be accepted at edge T+LATENCY+2.
- rdata_o and err_o hold their values after ack until the next commit. A store commit leaves rdata_o unchanged.
- Read-after-write to the same address returns the new data; commit happens before any later read.
- Counter width is clog2(LATENCY)+1 bits; no wrap, since it is reloaded on every acceptance.
- Inputs are ignored after latching; req_i dropping in BUSY does not abort the access (the ack still fires).
- Full 32-bit word accesses only; no byte enables.

Test Plan:
- Store then load, LATENCY=3:
  - req store addr=0x10, wdata=0xDEADBEEF accepted at edge T -> ack_o high after edge T+3, err_o=0; stall_o=1 from request assertion through BUSY.
  - Then load addr=0x10 -> rdata_o=0xDEADBEEF with ack.
- Misaligned load addr=0x13 -> ack after LATENCY edges, err_o=1, rdata_o=0; memory unchanged (load 0x10 still returns 0xDEADBEEF).
- Out-of-range store addr=0x200 (word 128, DEPTH=128) -> err_o=1, no write; load addr=0x0 still returns 0.
- Back-to-back: req_i held high across two loads (0x4, 0x8) -> ack pulses separated by exactly LATENCY+2 cycles; ready_o=1 only in the IDLE cycle between them.
- Reset during BUSY of store addr=0x20, wdata=0x12345678 -> state IDLE, ack_o=0, ready_o=1 immediately; subsequent load 0x20 returns 0.
- LATENCY=1 build: store/load of 0xA5A5A5A5 at addr=0x4 -> ack one edge after acceptance, load data correct.
